// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: shared types and defaults for the interval timer
package interval_timer_pkg;
   localparam int COUNT_BITS_DEFAULT = 10;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/interval_timer_if.sv
// interval_timer_if: load handshake, control and status signals of the interval timer
interface interval_timer_if
   import interval_timer_pkg::*;
   #(parameter int COUNT_BITS = COUNT_BITS_DEFAULT);
   logic                  load_valid;
   logic                  load_ready;
   logic [COUNT_BITS-1:0] load_count;
   logic                  periodic;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic                  done_pulse;
   logic [COUNT_BITS-1:0] remaining;
   modport master (
      output load_valid, load_count, periodic, abort,
      input  load_ready, busy, done, done_pulse, remaining
   );
   modport slave (
      input  load_valid, load_count, periodic, abort,
      output load_ready, busy, done, done_pulse, remaining
   );
endinterface

// File: rtl/interval_timer.sv
// interval_timer: programmable down-counting interval generator with one-shot and periodic modes
module interval_timer
   import interval_timer_pkg::*;
   #(parameter int COUNT_BITS = COUNT_BITS_DEFAULT)
   (
      input  logic            clock,
      input  logic            reset,
      interval_timer_if.slave bus
   );
   state_t                state, state_n;
   logic [COUNT_BITS-1:0] remaining_q, remaining_n;
   logic [COUNT_BITS-1:0] reload_q, reload_n;
   logic [COUNT_BITS-1:0] load_eff;
   logic                  periodic_q, periodic_n;
   logic                  done_q, done_n;
   logic                  pulse_q, pulse_n;
   logic                  ready;
   logic                  accept;
   logic                  terminal;
   // A zero-length request still produces one full cycle of delay.
   assign load_eff = (bus.load_count == '0) ? COUNT_BITS'(1) : bus.load_count;
   assign ready    = (state != RUN) && !bus.abort;
   assign accept   = bus.load_valid && ready;
   // Treat 0 as terminal too so the counter can never wrap below zero.
   assign terminal = remaining_q <= COUNT_BITS'(1);
   assign bus.load_ready = ready;
   assign bus.busy       = (state == RUN);
   assign bus.done       = done_q;
   assign bus.done_pulse = pulse_q;
   assign bus.remaining  = remaining_q;
   // Next-state and datapath: abort beats load, load beats counting.
   always_comb begin
      state_n     = state;
      remaining_n = remaining_q;
      reload_n    = reload_q;
      periodic_n  = periodic_q;
      done_n      = done_q;
      pulse_n     = 1'b0;
      if (bus.abort) begin
         state_n     = IDLE;
         remaining_n = '0;
         done_n      = 1'b0;
      end else if (accept) begin
         state_n     = RUN;
         remaining_n = load_eff;
         reload_n    = load_eff;
         periodic_n  = bus.periodic;
         done_n      = 1'b0;
      end else if (state == RUN) begin
         if (terminal) begin
            pulse_n = 1'b1;
            if (periodic_q) begin
               remaining_n = reload_q;
            end else begin
               state_n     = DONE;
               remaining_n = '0;
               done_n      = 1'b1;
            end
         end else begin
            remaining_n = remaining_q - COUNT_BITS'(1);
         end
      end
   end
   // State and output registers, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         remaining_q <= '0;
         reload_q    <= '0;
         periodic_q  <= 1'b0;
         done_q      <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         state       <= state_n;
         remaining_q <= remaining_n;
         reload_q    <= reload_n;
         periodic_q  <= periodic_n;
         done_q      <= done_n;
         pulse_q     <= pulse_n;
      end
   end
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed and random checks of interval_timer against an elapsed-time model
module tb_interval_timer;
   import interval_timer_pkg::*;
   localparam int CB = COUNT_BITS_DEFAULT;
   logic  clock = 1'b0;
   logic  reset = 1'b1;
   interval_timer_if #(.COUNT_BITS(CB)) bus ();
   interval_timer #(.COUNT_BITS(CB)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   int    checks = 0;
   int    failures = 0;
   int    edge_n = 0;
   bit    loaded = 1'b0;
   bit    m_per = 1'b0;
   int    load_edge = 0;
   int    m_n = 1;
   string phase = "reset";
   function automatic int elapsed();
      return edge_n - load_edge;
   endfunction
   function automatic bit running();
      return loaded && (m_per || elapsed() < m_n);
   endfunction
   function automatic int exp_rem();
      if (!loaded) return 0;
      if (m_per) return m_n - (elapsed() % m_n);
      return (elapsed() < m_n) ? m_n - elapsed() : 0;
   endfunction
   function automatic bit exp_done();
      return loaded && !m_per && elapsed() >= m_n;
   endfunction
   function automatic bit exp_pulse();
      if (!loaded || elapsed() == 0) return 1'b0;
      return m_per ? (elapsed() % m_n == 0) : (elapsed() == m_n);
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
      end
   endtask
   task automatic check_out();
      chk("remaining", 32'(bus.remaining), exp_rem());
      chk("done", 32'(bus.done), 32'(exp_done()));
      chk("done_pulse", 32'(bus.done_pulse), 32'(exp_pulse()));
      chk("busy", 32'(bus.busy), 32'(running()));
   endtask
   task automatic drive(input bit lv, input int cnt, input bit per, input bit ab);
      bus.load_valid = lv;
      bus.load_count = CB'(cnt);
      bus.periodic   = per;
      bus.abort      = ab;
   endtask
   task automatic tick();
      bit acc;
      bit ab;
      int cnt;
      bit per;
      #1;
      acc = bus.load_valid && !running() && !bus.abort;
      ab  = bus.abort;
      cnt = int'(bus.load_count);
      per = bus.periodic;
      chk("load_ready", 32'(bus.load_ready), 32'(!running() && !ab));
      @(posedge clock);
      edge_n++;
      if (ab) begin
         loaded = 1'b0;
      end else if (acc) begin
         loaded    = 1'b1;
         load_edge = edge_n;
         m_n       = (cnt == 0) ? 1 : cnt;
         m_per     = per;
      end
      #1;
      check_out();
   endtask
   task automatic run(input int k);
      drive(0, 0, 0, 0);
      for (int i = 0; i < k; i++) tick();
   endtask
   task automatic load(input int n, input bit per);
      drive(1, n, per, 0);
      tick();
      drive(0, 0, 0, 0);
   endtask
   initial begin
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #2;
      check_out();
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 32'(bus.load_ready), 32'd1);
      @(posedge clock);
      #1;
      phase = "oneshot5";
      load(5, 0);
      run(6);
      phase = "periodic3";
      load(3, 1);
      run(10);
      drive(0, 0, 0, 1);
      tick();
      phase = "zero_as_one";
      load(0, 0);
      run(2);
      phase = "reload_from_done";
      load(2, 0);
      run(3);
      phase = "abort_terminal";
      load(4, 0);
      run(3);
      chk("rem_before_abort", 32'(bus.remaining), 32'd1);
      drive(0, 0, 0, 1);
      tick();
      phase = "abort_with_load";
      drive(1, 3, 0, 1);
      tick();
      run(2);
      phase = "load_during_run";
      load(8, 0);
      drive(1, 2, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      run(4);
      phase = "max_count";
      load(1023, 0);
      run(1024);
      phase = "reset_mid_run";
      load(8, 0);
      run(4);
      chk("rem_before_reset", 32'(bus.remaining), 32'd4);
      #2;
      reset = 1'b1;
      #1;
      loaded = 1'b0;
      check_out();
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check_out();
      chk("ready_after_rerelease", 32'(bus.load_ready), 32'd1);
      @(posedge clock);
      #1;
      phase = "random";
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 9), 1'($urandom_range(0, 1)),
               $urandom_range(0, 24) == 0);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
